fp_add_arbiter: RTL and testbench

FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

---
 rtl/fp_add_arbiter_if.sv | 23 ++
 rtl/fp_add_arbiter.sv | 108 ++++++++++
 tb/tb_fp_add_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_add_arbiter_if.sv
// Bus between the arbiter and the shared pipelined FP adder: issue strobe,
// operands and op select out; result, flags and done strobe back.
interface fp_add_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             add_val;
    logic             add_subOp;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_out;
    logic [4:0]       add_flags;
    logic             add_done;

    modport master (
        output add_val, add_subOp, add_a, add_b,
        input  add_out, add_flags, add_done
    );

    modport slave (
        input  add_val, add_subOp, add_a, add_b,
        output add_out, add_flags, add_done
    );
endinterface

// File: rtl/fp_add_arbiter.sv
// Two-requester round-robin front end for a shared, fully pipelined FP adder;
// a tag pipe matched to the adder depth routes each result to its requester.
module fp_add_arbiter #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req0_valid,
    input  logic [WIDTH-1:0]              req0_a,
    input  logic [WIDTH-1:0]              req0_b,
    input  logic                          req0_sub,
    output logic                          req0_ready,
    input  logic                          req1_valid,
    input  logic [WIDTH-1:0]              req1_a,
    input  logic [WIDTH-1:0]              req1_b,
    input  logic                          req1_sub,
    output logic                          req1_ready,
    output logic                          resp0_valid,
    output logic [WIDTH-1:0]              resp0_out,
    output logic [4:0]                    resp0_flags,
    output logic                          resp1_valid,
    output logic [WIDTH-1:0]              resp1_out,
    output logic [4:0]                    resp1_flags,
    fp_add_arbiter_if.master              adder,
    output logic [$clog2(LATENCY+2)-1:0]  inflight,
    output logic                          protocol_err
);
    localparam int CNT_W = $clog2(LATENCY + 2);

    logic             prio_q;
    logic             accept;
    logic             accept_id;
    logic             tag_v;
    logic             tag_id;
    logic             deliver;
    logic             mismatch;
    logic [LATENCY:0] tag_valid_q;
    logic [LATENCY:0] tag_id_q;

    // Grant: contention goes to prio, a lone requester always wins.
    always_comb begin
        req0_ready = !reset && req0_valid && (!req1_valid || !prio_q);
        req1_ready = !reset && req1_valid && (!req0_valid ||  prio_q);
    end

    assign accept    = req0_ready || req1_ready;
    assign accept_id = req1_ready;
    assign tag_v     = tag_valid_q[LATENCY];
    assign tag_id    = tag_id_q[LATENCY];

    always_comb begin
        deliver     = !reset && adder.add_done && tag_v;
        mismatch    = adder.add_done != tag_v;
        resp0_valid = deliver && !tag_id;
        resp1_valid = deliver &&  tag_id;
        resp0_out   = adder.add_out;
        resp1_out   = adder.add_out;
        resp0_flags = adder.add_flags;
        resp1_flags = adder.add_flags;
    end

    // NOTE: tag ids have no reset; the matching valid bit alone decides whether a slot is live.
    always_ff @(posedge clk) begin
        tag_id_q[0] <= accept_id;
        for (int i = 1; i <= LATENCY; i++) begin
            tag_id_q[i] <= tag_id_q[i-1];
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q          <= 1'b0;
            adder.add_val   <= 1'b0;
            adder.add_subOp <= 1'b0;
            adder.add_a     <= '0;
            adder.add_b     <= '0;
            tag_valid_q     <= '0;
            inflight        <= '0;
            protocol_err    <= 1'b0;
        end else begin
            adder.add_val <= accept;
            if (accept) begin
                adder.add_a     <= accept_id ? req1_a   : req0_a;
                adder.add_b     <= accept_id ? req1_b   : req0_b;
                adder.add_subOp <= accept_id ? req1_sub : req0_sub;
                prio_q          <= !accept_id;
            end

            tag_valid_q[0] <= accept;
            for (int i = 1; i <= LATENCY; i++) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
            end

            if (accept && !deliver) begin
                inflight <= inflight + CNT_W'(1);
            end else if (!accept && deliver) begin
                inflight <= inflight - CNT_W'(1);
            end

            // Sticky until reset: a done without a tag, or a tag without a done.
            if (mismatch) begin
                protocol_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter with a table-driven stand-in for the
// pipelined FP adder; expected results are hand-computed IEEE-754 values.
module tb_fp_add_arbiter;
    localparam int WIDTH   = 32;
    localparam int LATENCY = 4;
    localparam int CNT_W   = $clog2(LATENCY + 2);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_sub = 1'b0, req1_sub = 1'b0;
    logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic             req0_ready, req1_ready;
    logic             resp0_valid, resp1_valid;
    logic [WIDTH-1:0] resp0_out, resp1_out;
    logic [4:0]       resp0_flags, resp1_flags;
    logic [CNT_W-1:0] inflight;
    logic             protocol_err;
    logic             inject = 1'b0;
    logic             suppress = 1'b0;
    int               total = 0;
    int               bad = 0;

    fp_add_arbiter_if #(.WIDTH(WIDTH)) bus();

    fp_add_arbiter #(.WIDTH(WIDTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub), .req1_ready(req1_ready),
        .resp0_valid(resp0_valid), .resp0_out(resp0_out), .resp0_flags(resp0_flags),
        .resp1_valid(resp1_valid), .resp1_out(resp1_out), .resp1_flags(resp1_flags),
        .adder(bus), .inflight(inflight), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    // Operation table: a op b = res (flags {invalid, infinite, overflow, underflow, inexact}).
    logic [31:0] tbl_a   [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F800000,
                                 32'h3FC00000, 32'h40800000, 32'h7F7FFFFF, 32'hC0000000};
    logic [31:0] tbl_b   [8] = '{32'h40000000, 32'h40000000, 32'h3F800000, 32'h3F800000,
                                 32'h3F000000, 32'h3F800000, 32'h7F7FFFFF, 32'h3F800000};
    logic        tbl_sub [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] tbl_res [8] = '{32'h40400000, 32'h40800000, 32'h40000000, 32'h00000000,
                                 32'h40000000, 32'h40400000, 32'h7F800000, 32'hBF800000};
    logic [4:0]  tbl_fl  [8] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b00101, 5'd0};

    function automatic logic [36:0] model_add(input logic [31:0] a, input logic [31:0] b, input logic s);
        for (int i = 0; i < 8; i++) begin
            if (a === tbl_a[i] && b === tbl_b[i] && s === tbl_sub[i]) return {tbl_fl[i], tbl_res[i]};
        end
        return {5'h1F, 32'hDEADBEEF};
    endfunction

    // Stand-in adder: LATENCY stages from add_val to add_done, shares reset.
    bit   [LATENCY-1:0] st_v;
    logic [31:0]        st_out [LATENCY];
    logic [4:0]         st_fl  [LATENCY];

    always @(posedge clk) begin
        if (reset) st_v <= '0;
        else       st_v <= {st_v[LATENCY-2:0], bus.add_val === 1'b1};
        {st_fl[0], st_out[0]} <= model_add(bus.add_a, bus.add_b, bus.add_subOp);
        for (int i = 1; i < LATENCY; i++) begin
            st_out[i] <= st_out[i-1];
            st_fl[i]  <= st_fl[i-1];
        end
    end

    assign bus.add_done  = (st_v[LATENCY-1] && !suppress) || inject;
    assign bus.add_out   = st_out[LATENCY-1];
    assign bus.add_flags = st_fl[LATENCY-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        inject     = 1'b0;
        suppress   = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        req0_valid = 1'b1; req0_a = tbl_a[0]; req0_b = tbl_b[0]; req0_sub = tbl_sub[0];
        req1_valid = 1'b1; req1_a = tbl_a[1]; req1_b = tbl_b[1]; req1_sub = tbl_sub[1];
        inject = 1'b1;
        tick();
        @(negedge clk);
        total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL reset_ready0: got %b want 0", req0_ready); end
        total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL reset_ready1: got %b want 0", req1_ready); end
        total++; if (resp0_valid !== 1'b0) begin bad++; $display("FAIL reset_resp0: got %b want 0", resp0_valid); end
        total++; if (resp1_valid !== 1'b0) begin bad++; $display("FAIL reset_resp1: got %b want 0", resp1_valid); end
        total++; if (bus.add_val !== 1'b0) begin bad++; $display("FAIL reset_add_val: got %b want 0", bus.add_val); end
        total++; if (bus.add_a !== 32'h0) begin bad++; $display("FAIL reset_add_a: got %h want 0", bus.add_a); end
        total++; if (bus.add_b !== 32'h0) begin bad++; $display("FAIL reset_add_b: got %h want 0", bus.add_b); end
        total++; if (bus.add_subOp !== 1'b0) begin bad++; $display("FAIL reset_add_subOp: got %b want 0", bus.add_subOp); end
        total++; if (inflight !== CNT_W'(0)) begin bad++; $display("FAIL reset_inflight: got %0d want 0", inflight); end
        total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", protocol_err); end
        tick();
        idle();
        reset = 1'b0;
        @(negedge clk);
        total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL reset_release_err: got %b want 0", protocol_err); end
        tick();
    endtask

    task automatic test_single();
        bit exp0;
        do_reset();
        req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_sub = 1'b0;
        @(negedge clk);
        total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL single_ready0: got %b want 1", req0_ready); end
        total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL single_ready1: got %b want 0", req1_ready); end
        tick();
        req0_valid = 1'b0;
        for (int c = 1; c <= LATENCY + 2; c++) begin
            exp0 = (c == LATENCY + 1);
            @(negedge clk);
            if (c == 1) begin
                total++; if (bus.add_val !== 1'b1) begin bad++; $display("FAIL single_add_val: got %b want 1", bus.add_val); end
                total++; if (bus.add_a !== 32'h3F800000) begin bad++; $display("FAIL single_add_a: got %h want 3f800000", bus.add_a); end
                total++; if (bus.add_b !== 32'h40000000) begin bad++; $display("FAIL single_add_b: got %h want 40000000", bus.add_b); end
                total++; if (bus.add_subOp !== 1'b0) begin bad++; $display("FAIL single_add_subOp: got %b want 0", bus.add_subOp); end
                total++; if (inflight !== CNT_W'(1)) begin bad++; $display("FAIL single_inflight1: got %0d want 1", inflight); end
            end
            if (c == 2) begin
                total++; if (bus.add_val !== 1'b0) begin bad++; $display("FAIL single_add_val_idle: got %b want 0", bus.add_val); end
                total++; if (bus.add_a !== 32'h3F800000) begin bad++; $display("FAIL single_add_a_hold: got %h want 3f800000", bus.add_a); end
            end
            total++; if (resp0_valid !== exp0) begin bad++; $display("FAIL single_resp0_c%0d: got %b want %b", c, resp0_valid, exp0); end
            total++; if (resp1_valid !== 1'b0) begin bad++; $display("FAIL single_resp1_c%0d: got %b want 0", c, resp1_valid); end
            if (exp0) begin
                total++; if (resp0_out !== 32'h40400000) begin bad++; $display("FAIL single_out: got %h want 40400000", resp0_out); end
                total++; if (resp0_flags !== 5'd0) begin bad++; $display("FAIL single_flags: got %b want 00000", resp0_flags); end
            end
            if (c == LATENCY + 2) begin
                total++; if (inflight !== CNT_W'(0)) begin bad++; $display("FAIL single_inflight0: got %0d want 0", inflight); end
            end
            tick();
        end
    endtask

    // mode 0: both requesters busy; mode 1: req1 busy, req0 pulses every 3rd cycle.
    task automatic run_traffic(input int mode, input int n, output int peak, output int g0, output int g1);
        bit acc [32];
        bit aid [32];
        int avec [32];
        int p, r0, r1, infl, op0, op1, src;
        bit v0, v1, e0, e1, x0, x1;
        p = 0; r0 = 0; r1 = 0; infl = 0; peak = 0; g0 = 0; g1 = 0;
        for (int c = 0; c < n + LATENCY + 2; c++) begin
            op0 = (mode == 0) ? 2 * r0 : 6 + (r0 % 2);
            op1 = (mode == 0) ? 2 * r1 + 1 : r1 % 6;
            v0 = (c < n) && ((mode == 0) || (c % 3 == 0));
            v1 = (c < n);
            req0_valid = v0; req0_a = tbl_a[op0]; req0_b = tbl_b[op0]; req0_sub = tbl_sub[op0];
            req1_valid = v1; req1_a = tbl_a[op1]; req1_b = tbl_b[op1]; req1_sub = tbl_sub[op1];
            e0 = v0 && (!v1 || p == 0);
            e1 = v1 && (!v0 || p == 1);
            src = c - 1 - LATENCY;
            x0 = (src >= 0) && acc[src] && !aid[src];
            x1 = (src >= 0) && acc[src] &&  aid[src];
            @(negedge clk);
            total++; if (req0_ready !== e0) begin bad++; $display("FAIL m%0d_ready0_c%0d: got %b want %b", mode, c, req0_ready, e0); end
            total++; if (req1_ready !== e1) begin bad++; $display("FAIL m%0d_ready1_c%0d: got %b want %b", mode, c, req1_ready, e1); end
            total++; if (resp0_valid !== x0) begin bad++; $display("FAIL m%0d_resp0_c%0d: got %b want %b", mode, c, resp0_valid, x0); end
            total++; if (resp1_valid !== x1) begin bad++; $display("FAIL m%0d_resp1_c%0d: got %b want %b", mode, c, resp1_valid, x1); end
            if (x0) begin
                total++; if ({resp0_flags, resp0_out} !== {tbl_fl[avec[src]], tbl_res[avec[src]]})
                    begin bad++; $display("FAIL m%0d_out0_c%0d: got %b/%h want %b/%h", mode, c, resp0_flags, resp0_out, tbl_fl[avec[src]], tbl_res[avec[src]]); end
            end
            if (x1) begin
                total++; if ({resp1_flags, resp1_out} !== {tbl_fl[avec[src]], tbl_res[avec[src]]})
                    begin bad++; $display("FAIL m%0d_out1_c%0d: got %b/%h want %b/%h", mode, c, resp1_flags, resp1_out, tbl_fl[avec[src]], tbl_res[avec[src]]); end
            end
            total++; if (inflight !== CNT_W'(infl)) begin bad++; $display("FAIL m%0d_inflight_c%0d: got %0d want %0d", mode, c, inflight, infl); end
            acc[c] = e0 || e1;
            aid[c] = e1;
            avec[c] = e1 ? op1 : op0;
            if (req0_ready === 1'b1) g0++;
            if (req1_ready === 1'b1) g1++;
            if (int'(inflight) > peak) peak = int'(inflight);
            infl = infl + int'(e0 || e1) - int'(x0 || x1);
            if (e0) begin p = 1; r0++; end
            if (e1) begin p = 0; r1++; end
            tick();
        end
        idle();
    endtask

    task automatic test_alternate();
        int peak, g0, g1;
        do_reset();
        run_traffic(0, 6, peak, g0, g1);
        total++; if (peak !== LATENCY + 1) begin bad++; $display("FAIL alt_peak: got %0d want %0d", peak, LATENCY + 1); end
        total++; if (g0 !== 3) begin bad++; $display("FAIL alt_grants0: got %0d want 3", g0); end
        total++; if (g1 !== 3) begin bad++; $display("FAIL alt_grants1: got %0d want 3", g1); end
    endtask

    task automatic test_fairness();
        int peak, g0, g1;
        do_reset();
        run_traffic(1, 12, peak, g0, g1);
        total++; if (g0 !== 4) begin bad++; $display("FAIL fair_grants0: got %0d want 4", g0); end
        total++; if (g1 !== 8) begin bad++; $display("FAIL fair_grants1: got %0d want 8", g1); end
    endtask

    task automatic test_protocol();
        do_reset();
        inject = 1'b1;
        @(negedge clk);
        total++; if (resp0_valid !== 1'b0) begin bad++; $display("FAIL proto_resp0: got %b want 0", resp0_valid); end
        total++; if (resp1_valid !== 1'b0) begin bad++; $display("FAIL proto_resp1: got %b want 0", resp1_valid); end
        total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL proto_err_early: got %b want 0", protocol_err); end
        tick();
        inject = 1'b0;
        @(negedge clk);
        total++; if (protocol_err !== 1'b1) begin bad++; $display("FAIL proto_err_set: got %b want 1", protocol_err); end
        tick(); tick(); tick();
        @(negedge clk);
        total++; if (protocol_err !== 1'b1) begin bad++; $display("FAIL proto_err_sticky: got %b want 1", protocol_err); end
        do_reset();
        @(negedge clk);
        total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL proto_err_clear: got %b want 0", protocol_err); end
        tick();
        // Result withheld by the adder while its tag emerges.
        for (int c = 0; c <= LATENCY + 3; c++) begin
            req0_valid = (c == 0); req0_a = tbl_a[3]; req0_b = tbl_b[3]; req0_sub = tbl_sub[3];
            suppress = (c == LATENCY + 1);
            @(negedge clk);
            if (c == LATENCY + 1) begin
                total++; if (resp0_valid !== 1'b0) begin bad++; $display("FAIL proto_missing_resp0: got %b want 0", resp0_valid); end
            end
            if (c == LATENCY + 2) begin
                total++; if (protocol_err !== 1'b1) begin bad++; $display("FAIL proto_missing_err: got %b want 1", protocol_err); end
                total++; if (inflight !== CNT_W'(1)) begin bad++; $display("FAIL proto_missing_inflight: got %0d want 1", inflight); end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_reset_midflight();
        bit exp1;
        do_reset();
        for (int c = 0; c <= 13 + LATENCY; c++) begin
            req0_valid = (c <= 3);
            req0_a = tbl_a[(c < 3) ? c : 7]; req0_b = tbl_b[(c < 3) ? c : 7]; req0_sub = tbl_sub[(c < 3) ? c : 7];
            req1_valid = (c == 11); req1_a = tbl_a[5]; req1_b = tbl_b[5]; req1_sub = tbl_sub[5];
            reset = (c == 3);
            exp1 = (c == 12 + LATENCY);
            @(negedge clk);
            if (c == 3) begin
                total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL mid_ready_in_reset: got %b want 0", req0_ready); end
                total++; if (inflight !== CNT_W'(3)) begin bad++; $display("FAIL mid_inflight3: got %0d want 3", inflight); end
            end
            if (c == 4) begin
                total++; if (inflight !== CNT_W'(0)) begin bad++; $display("FAIL mid_inflight_cleared: got %0d want 0", inflight); end
                total++; if (bus.add_val !== 1'b0) begin bad++; $display("FAIL mid_add_val: got %b want 0", bus.add_val); end
            end
            total++; if (resp0_valid !== 1'b0) begin bad++; $display("FAIL mid_resp0_c%0d: got %b want 0", c, resp0_valid); end
            total++; if (resp1_valid !== exp1) begin bad++; $display("FAIL mid_resp1_c%0d: got %b want %b", c, resp1_valid, exp1); end
            if (exp1) begin
                total++; if (resp1_out !== 32'h40400000) begin bad++; $display("FAIL mid_out1: got %h want 40400000", resp1_out); end
            end
            if (c == 13 + LATENCY) begin
                total++; if (inflight !== CNT_W'(0)) begin bad++; $display("FAIL mid_inflight_end: got %0d want 0", inflight); end
                total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL mid_err: got %b want 0", protocol_err); end
            end
            tick();
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_fairness();
        test_protocol();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
